spi_coef_regfile: RTL and testbench
===================================

SPI_COEF_REGFILE -- requirements
Module: spi_coef_regfile

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of modulator channels, each with one cos and one sin coefficient bank.
REQ-002 SHALL have parameter N_TAP, default 8: coefficients per bank.
REQ-003 SHALL have parameter COEF_W, default 5: bits per coefficient.
REQ-004 SHALL have parameter DATA_W, default 24: data bits per frame; TPW = DATA_W/COEF_W coefficients per word; N_TAP divisible by TPW.
REQ-005 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port SCLK, input, 1: SPI clock, asynchronous to clk; clk at least 4x SCLK.
REQ-008 SHALL have port ss, input, 1: slave select, active low, asynchronous.
REQ-009 SHALL have port MOSI, input, 1: serial data in, MSB first.
REQ-010 SHALL have port MISO, output, 1: serial read-back data.
REQ-011 SHALL have port coef_o, output, N_CH*2*N_TAP*COEF_W: active coefficients; channel c cos tap t at index ((c*2+0)*N_TAP+t)*COEF_W, sin at (c*2+1).
REQ-012 SHALL have port commit_o, output, 1: one-clk pulse when shadow is copied to active.
REQ-013 SHALL have port frame_err_o, output, 1: one-clk pulse on a malformed frame.

Function
REQ-014 SHALL pass SCLK, ss and MOSI through 2-flop synchronizers; SCLK edges detected from the synchronized value; mode 0.
REQ-015 SHALL sample MOSI on each detected SCLK rising edge and update MISO on each detected falling edge.
REQ-016 SHALL frame as 8-bit command (bit7 = 1 write / 0 read, bits6:0 address) followed by DATA_W data bits; FRAME_LEN = 8+DATA_W.
REQ-017 SHALL implement FSM IDLE -> CMD on synchronized ss low; CMD -> DATA after 8 bits; DATA -> DONE after DATA_W bits; any state -> IDLE on ss high.
REQ-018 SHALL map word address a in 1..N_WORDS (N_WORDS = 2*N_CH*N_TAP/TPW) to the shadow word a-1, in coef_o packing order, TPW coefficients in data bits [TPW*COEF_W-1:0]; upper data bits ignored.
REQ-019 SHALL perform a write to shadow in the clk cycle after entering DONE; active coef_o unchanged.
REQ-020 SHALL treat a write to address 7'h7F as commit: all shadow copied to coef_o in one cycle, commit_o pulses; data ignored.
REQ-021 SHALL ignore writes to address 0 or to 7'h7F>a>N_WORDS without error.
REQ-022 SHALL, on a read command, load the addressed shadow word (zero-extended to DATA_W; 0 for invalid address) at CMD->DATA and shift it out MSB first during DATA.
REQ-023 SHALL pulse frame_err_o and discard the frame when ss rises in CMD or DATA, or when an SCLK edge arrives in DONE.
REQ-024 SHALL hold MISO at 0 outside DATA of a read frame.

Reset
REQ-025 SHALL, while reset high, clear shadow, coef_o, FSM (IDLE), bit counter, shift registers, synchronizers, MISO, commit_o, frame_err_o to 0.
REQ-026 SHALL abort any frame in progress on reset; a frame whose ss was already low when reset falls is ignored until ss returns high.

Configuration
REQ-027 SHALL, with SPI_READBACK_EN defined, implement REQ-022/024 read-back.
REQ-028 SHALL, without SPI_READBACK_EN, tie MISO to 0, omit the transmit shifter, and treat read frames as no-ops (framing errors still reported).

Structure
REQ-029 SHALL place FSM state enum, command-bit position, COMMIT_ADDR = 7'h7F and CMD_W = 8 in package spi_coef_pkg.
REQ-030 SHALL isolate synchronizers, edge detection and shift registers in sub-module spi_frontend.

Verification
REQ-031 SHALL cover: write addr 1 data 24'h0F_FFFF (defaults) -> shadow word0 = 20'hFFFFF, coef_o still 0, commit_o 0.
REQ-032 SHALL cover: after REQ-031, write addr 7'h7F -> commit_o single pulse, coef_o[19:0] = 20'hFFFFF, rest 0.
REQ-033 SHALL cover: read addr 1 after REQ-031 -> MISO carries 24'h0F_FFFF MSB first; without SPI_READBACK_EN MISO stays 0.
REQ-034 SHALL cover: ss raised after 20 bits of a write to addr 2 -> frame_err_o pulse, shadow word1 unchanged.
REQ-035 SHALL cover: 33 SCLK pulses in one frame writing addr 3 -> write performed, frame_err_o pulses once.
REQ-036 SHALL cover: reset asserted mid-frame then released with ss low -> no write, coef_o 0, next clean frame succeeds.

Source files
------------

// File: rtl/spi_coef_pkg.sv
// Shared constants and FSM encoding for the SPI coefficient register file.
package spi_coef_pkg;

    localparam int CMD_W      = 8;
    localparam int ADDR_W     = CMD_W - 1;
    localparam int CMD_WR_BIT = CMD_W - 1;

    localparam logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'('h7F);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_frontend.sv
// SPI synchronizers, SCLK edge detection, receive shifter and (with SPI_READBACK_EN) the
// MISO transmit shifter. Without SPI_READBACK_EN the tx ports are absent and miso is tied low.
module spi_frontend
    import spi_coef_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int COEF_W = 5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 sclk,
    input  logic                                 ss,
    input  logic                                 mosi,
`ifdef SPI_READBACK_EN
    input  logic                                 tx_load,
    input  logic                                 tx_en,
    input  logic [DATA_W-1:0]                    tx_word,
`endif
    output logic                                 sclk_rise,
    output logic                                 ss_sync,
    output logic [CMD_W-1:0]                     cmd_next,
    output logic [(DATA_W/COEF_W)*COEF_W-1:0]    rx_data,
    output logic                                 miso
);

    localparam int WORD_W = (DATA_W / COEF_W) * COEF_W;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic ss_s1, ss_s2;
    logic mosi_s1, mosi_s2;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign ss_sync   = ss_s2;
    // Command byte including the bit being sampled this cycle, so the FSM can decode it on the 8th edge.
    assign cmd_next  = {rx_data[CMD_W-2:0], mosi_s2};

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            ss_s1   <= 1'b0;
            ss_s2   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            rx_data <= '0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            ss_s1   <= ss;
            ss_s2   <= ss_s1;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            if (sclk_rise)
                rx_data <= {rx_data[WORD_W-2:0], mosi_s2};
        end
    end

`ifdef SPI_READBACK_EN
    logic              sclk_fall;
    logic [DATA_W-1:0] tx_shift;

    assign sclk_fall = ~sclk_s2 & sclk_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift <= '0;
            miso     <= 1'b0;
        end else begin
            if (tx_load)
                tx_shift <= tx_word;
            else if (tx_en && sclk_fall)
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

            if (!tx_en)
                miso <= 1'b0;
            else if (sclk_fall)
                miso <= tx_shift[DATA_W-1];
        end
    end
`else
    assign miso = 1'b0;
`endif

endmodule

// File: rtl/spi_coef_regfile.sv
// SPI-loaded coefficient register file: writes land in a shadow bank, a write to COMMIT_ADDR
// copies the shadow to coef_o. SPI_READBACK_EN adds shadow read-back on MISO.
//
// state | meaning
// IDLE  | waiting for ss low; a frame already open at reset release is skipped until ss goes high
// CMD   | shifting in the 8-bit command
// DATA  | shifting in write data / shifting out read data
// DONE  | frame complete; write executes next cycle, any further SCLK rise is a framing error
module spi_coef_regfile
    import spi_coef_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int N_TAP  = 8,
    parameter int COEF_W = 5,
    parameter int DATA_W = 24
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            SCLK,
    input  logic                            ss,
    input  logic                            MOSI,
    output logic                            MISO,
    output logic [N_CH*2*N_TAP*COEF_W-1:0]  coef_o,
    output logic                            commit_o,
    output logic                            frame_err_o
);

    localparam int TPW     = DATA_W / COEF_W;
    localparam int WORD_W  = TPW * COEF_W;
    localparam int N_WORDS = 2 * N_CH * N_TAP / TPW;
    localparam int CNT_W   = $clog2(DATA_W > CMD_W ? DATA_W : CMD_W);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS);

    spi_state_t                      state;
    logic [CNT_W-1:0]                bit_cnt;
    logic                            armed;
    logic                            wr_pend;
    logic                            cmd_last;
    logic [CMD_W-1:0]                cmd_reg;
    logic [CMD_W-1:0]                cmd_next;
    logic [WORD_W-1:0]               rx_data;
    logic                            sclk_rise;
    logic                            ss_sync;
    logic [ADDR_W-1:0]               wr_addr;
    logic                            wr_valid;
    logic [N_CH*2*N_TAP*COEF_W-1:0]  shadow;

    assign cmd_last = (state == ST_CMD) && !ss_sync && sclk_rise && (bit_cnt == '0);
    assign wr_addr  = cmd_reg[ADDR_W-1:0];
    assign wr_valid = (wr_addr != '0) && (wr_addr <= LAST_ADDR);

`ifdef SPI_READBACK_EN
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] tx_word;
    logic              tx_load;
    logic              tx_en;

    assign rd_addr = cmd_next[ADDR_W-1:0];
    assign tx_load = cmd_last && !cmd_next[CMD_WR_BIT];
    assign tx_en   = (state == ST_DATA) && !cmd_reg[CMD_WR_BIT];

    always_comb begin
        tx_word = '0;
        if ((rd_addr != '0) && (rd_addr <= LAST_ADDR))
            tx_word[WORD_W-1:0] = shadow[int'(rd_addr - ADDR_W'(1)) * WORD_W +: WORD_W];
    end
`endif

    spi_frontend #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_frontend (
        .clk       (clk),
        .reset     (reset),
        .sclk      (SCLK),
        .ss        (ss),
        .mosi      (MOSI),
`ifdef SPI_READBACK_EN
        .tx_load   (tx_load),
        .tx_en     (tx_en),
        .tx_word   (tx_word),
`endif
        .sclk_rise (sclk_rise),
        .ss_sync   (ss_sync),
        .cmd_next  (cmd_next),
        .rx_data   (rx_data),
        .miso      (MISO)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            armed       <= 1'b0;
            wr_pend     <= 1'b0;
            cmd_reg     <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            wr_pend     <= 1'b0;
            if (ss_sync)
                armed <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (!ss_sync && armed) begin
                        state   <= ST_CMD;
                        bit_cnt <= CNT_W'(CMD_W - 1);
                    end
                end
                ST_CMD: begin
                    if (ss_sync) begin
                        state       <= ST_IDLE;
                        frame_err_o <= 1'b1;
                    end else if (sclk_rise) begin
                        if (bit_cnt == '0) begin
                            state   <= ST_DATA;
                            bit_cnt <= CNT_W'(DATA_W - 1);
                            cmd_reg <= cmd_next;
                        end else begin
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (ss_sync) begin
                        state       <= ST_IDLE;
                        frame_err_o <= 1'b1;
                    end else if (sclk_rise) begin
                        if (bit_cnt == '0) begin
                            state   <= ST_DONE;
                            wr_pend <= cmd_reg[CMD_WR_BIT];
                        end else begin
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // The falling edge closing the last bit is legal; only an extra rising edge is an overrun.
                    if (ss_sync) begin
                        state <= ST_IDLE;
                    end else if (sclk_rise) begin
                        state       <= ST_IDLE;
                        armed       <= 1'b0;
                        frame_err_o <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow   <= '0;
            coef_o   <= '0;
            commit_o <= 1'b0;
        end else begin
            commit_o <= 1'b0;
            if (wr_pend) begin
                if (wr_addr == COMMIT_ADDR) begin
                    coef_o   <= shadow;
                    commit_o <= 1'b1;
                end else if (wr_valid) begin
                    shadow[int'(wr_addr - ADDR_W'(1)) * WORD_W +: WORD_W] <= rx_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_coef_regfile.sv
// Directed scoreboard bench for spi_coef_regfile at default parameters.
// MISO expectations follow SPI_READBACK_EN when the bench is compiled with it defined.
module tb_spi_coef_regfile;

    localparam int CW   = 160;
    localparam int HALF = 60;
`ifdef SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          SCLK  = 1'b0;
    logic          ss    = 1'b1;
    logic          MOSI  = 1'b0;
    logic          MISO;
    logic [CW-1:0] coef_o;
    logic          commit_o;
    logic          frame_err_o;

    int n_assert   = 0;
    int n_fail     = 0;
    int n_commit   = 0;
    int n_err      = 0;
    int exp_commit = 0;
    int exp_err    = 0;

    logic [CW-1:0] m_shadow = '0;
    logic [CW-1:0] m_active = '0;
    logic [CW-1:0] exp_coef[$];
    logic [CW-1:0] got_coef[$];
    logic          exp_miso[$];

    spi_coef_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .SCLK        (SCLK),
        .ss          (ss),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .coef_o      (coef_o),
        .commit_o    (commit_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (commit_o) begin
            n_commit++;
            got_coef.push_back(coef_o);
        end
        if (frame_err_o)
            n_err++;
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [31:0] f, input int first, input int last, input bit chk);
        logic e;
        for (int i = first; i < last; i++) begin
            MOSI = (i < 32) ? f[31 - i] : 1'b0;
            #(HALF);
            if (chk) begin
                e = (exp_miso.size() == 0) ? 1'bx : exp_miso.pop_front();
                check("miso_bit", CW'(MISO), CW'(e));
            end
            SCLK = 1'b1;
            #(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] f, input int nbits, input bit chk);
        ss = 1'b0;
        send_bits(f, 0, nbits, chk);
        #(HALF);
        ss = 1'b1;
        #(4 * HALF);
    endtask

    task automatic model_write(input logic [6:0] a, input logic [23:0] d);
        if (a == 7'h7F) begin
            m_active = m_shadow;
            exp_coef.push_back(m_shadow);
            exp_commit++;
        end else if (a >= 7'd1 && a <= 7'd8) begin
            m_shadow[(a - 1) * 20 +: 20] = d[19:0];
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [23:0] d);
        model_write(a, d);
        spi_frame({1'b1, a, d}, 32, 1'b0);
    endtask

    task automatic do_read(input logic [6:0] a);
        logic [23:0] w;
        w = '0;
        if (a >= 7'd1 && a <= 7'd8)
            w[19:0] = m_shadow[(a - 1) * 20 +: 20];
        for (int i = 0; i < 8; i++)
            exp_miso.push_back(1'b0);
        for (int i = 23; i >= 0; i--)
            exp_miso.push_back(w[i] & READBACK);
        spi_frame({1'b0, a, 24'h0}, 32, 1'b1);
        check("miso_idle_after_read", CW'(MISO), '0);
    endtask

    task automatic check_commit(input string tag);
        logic [CW-1:0] g;
        logic [CW-1:0] e;
        g = (got_coef.size() == 0) ? 'x : got_coef.pop_front();
        e = (exp_coef.size() == 0) ? '0 : exp_coef.pop_front();
        check(tag, g, e);
        check({tag, "_live"}, coef_o, m_active);
        check({tag, "_count"}, CW'(n_commit), CW'(exp_commit));
    endtask

    initial begin
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_miso", CW'(MISO), '0);
        check("reset_coef", coef_o, '0);
        check("reset_commit", CW'(commit_o), '0);
        check("reset_frame_err", CW'(frame_err_o), '0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // write to shadow only
        do_write(7'd1, 24'h0F_FFFF);
        check("coef_before_commit", coef_o, '0);
        check("no_commit_on_write", CW'(n_commit), '0);

        do_read(7'd1);

        do_write(7'h7F, 24'hAB_CDEF);
        check_commit("commit_word0");

        // ss raised after 20 bits of a write to address 2
        ss = 1'b0;
        send_bits({1'b1, 7'd2, 24'h0A_AAAA}, 0, 20, 1'b0);
        #(HALF);
        ss = 1'b1;
        #(4 * HALF);
        exp_err++;
        check("abort_err_cnt", CW'(n_err), CW'(exp_err));
        do_write(7'h7F, 24'h00_0000);
        check_commit("commit_after_abort");

        // 33 clocks on a write to address 3
        model_write(7'd3, 24'h01_2345);
        spi_frame({1'b1, 7'd3, 24'h01_2345}, 33, 1'b0);
        exp_err++;
        check("overrun_err_cnt", CW'(n_err), CW'(exp_err));
        do_write(7'h7F, 24'h5A_5A5A);
        check_commit("commit_after_overrun");

        // address boundaries
        do_write(7'd0, 24'hFF_FFFF);
        do_write(7'd9, 24'hFF_FFFF);
        do_write(7'd8, 24'hF5_5555);
        do_write(7'd2, 24'h3C_3C3C);
        do_write(7'h7F, 24'h00_0000);
        check_commit("commit_boundaries");
        check("boundary_err_cnt", CW'(n_err), CW'(exp_err));

        do_read(7'd8);
        do_read(7'd9);
        do_read(7'd2);

        // reset in the middle of a write, released with ss still low
        ss = 1'b0;
        send_bits({1'b1, 7'd4, 24'hFF_FFFF}, 0, 10, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset    = 1'b0;
        m_shadow = '0;
        m_active = '0;
        check("coef_after_reset", coef_o, '0);
        send_bits({1'b1, 7'd4, 24'hFF_FFFF}, 10, 32, 1'b0);
        #(HALF);
        ss = 1'b1;
        #(4 * HALF);
        check("no_err_after_reset", CW'(n_err), CW'(exp_err));
        check("no_commit_after_reset", CW'(n_commit), CW'(exp_commit));
        check("coef_still_zero", coef_o, '0);

        do_write(7'd4, 24'h0A_BCDE);
        do_write(7'h7F, 24'h00_0000);
        check_commit("commit_after_reset");
        do_read(7'd4);

        check("final_err_cnt", CW'(n_err), CW'(exp_err));
        check("final_commit_cnt", CW'(n_commit), CW'(exp_commit));
        check("unclaimed_commits", CW'(got_coef.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
